sprite_banner_anim: RTL and testbench

- Parametrised successor to the fixed 90x16 "winner" banner sprite locator for the VGA path.
- Tests the beam position against a sprite box whose size and integer scale are set by parameters, and drives a synchronous glyph ROM.
- Adds a per-frame animation: a vertical slide-in to a target row, a blink phase, then steady display.
- Outputs a pipelined, registered `visible` bit to the pixel mux, aligned to the ROM read latency.

---
 rtl/sprite_banner_anim.sv | 166 ++++++++++++++++
 tb/tb_sprite_banner_anim.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_banner_anim.sv
// Banner sprite locator with slide-in / blink / steady animation.
// Three-stage pixel pipeline aligned to a synchronous glyph ROM.
module sprite_banner_anim #(
  parameter int SPR_W         = 90,
  parameter int SPR_H         = 16,
  parameter int SCALE_LOG2    = 0,
  parameter int START_Y       = 0,
  parameter int STEP          = 4,
  parameter int BLINK_PERIOD  = 15,
  parameter int BLINK_TOGGLES = 6,
  localparam int AW = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       beam_x,
  input  logic [9:0]       beam_y,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic [9:0]       org_x,
  input  logic [9:0]       tgt_y,
  output logic [AW-1:0]    rom_addr,
  input  logic [SPR_W-1:0] rom_data,
  output logic             visible,
  output logic             busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SLIDE  = 2'd1;
  localparam logic [1:0] BLINK  = 2'd2;
  localparam logic [1:0] STEADY = 2'd3;

  localparam int EW = SPR_W << SCALE_LOG2;
  localparam int EH = SPR_H << SCALE_LOG2;
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int TW = $clog2(BLINK_TOGGLES + 1);

  logic [1:0]    state, state_nxt;
  logic [9:0]    cur_y, cur_y_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic [TW-1:0] tog_cnt, tog_cnt_nxt;
  logic          phase, phase_nxt;
  logic [10:0]   slide_sum;
  logic [9:0]    slide_y;

  // Slide target clamps in 11 bits so a large STEP near the bottom cannot wrap.
  assign slide_sum = {1'b0, cur_y} + 11'(STEP);
  assign slide_y   = (slide_sum >= {1'b0, tgt_y}) ? tgt_y : slide_sum[9:0];

  always_comb begin
    state_nxt     = state;
    cur_y_nxt     = cur_y;
    blink_cnt_nxt = blink_cnt;
    tog_cnt_nxt   = tog_cnt;
    phase_nxt     = phase;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SLIDE;
          cur_y_nxt = 10'(START_Y);
          phase_nxt = 1'b1;
        end
        SLIDE: begin
          if (frame_tick) begin
            cur_y_nxt = slide_y;
            if (slide_y == tgt_y) begin
              state_nxt     = BLINK;
              blink_cnt_nxt = '0;
              tog_cnt_nxt   = '0;
            end
          end
        end
        BLINK: begin
          if (frame_tick) begin
            if (blink_cnt == BW'(BLINK_PERIOD - 1)) begin
              blink_cnt_nxt = '0;
              tog_cnt_nxt   = tog_cnt + 1'b1;
              if (tog_cnt == TW'(BLINK_TOGGLES - 1)) begin
                state_nxt = STEADY;
                phase_nxt = 1'b1;
              end else begin
                phase_nxt = ~phase;
              end
            end else begin
              blink_cnt_nxt = blink_cnt + 1'b1;
            end
          end
        end
        default: begin
          phase_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_y     <= 10'(START_Y);
      blink_cnt <= '0;
      tog_cnt   <= '0;
      phase     <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_y     <= cur_y_nxt;
      blink_cnt <= blink_cnt_nxt;
      tog_cnt   <= tog_cnt_nxt;
      phase     <= phase_nxt;
      busy      <= (state_nxt == SLIDE) || (state_nxt == BLINK);
    end
  end

  logic [10:0]   x_lo, x_hi, y_lo, y_hi;
  logic          hit_c;
  logic [CW-1:0] col_c;
  logic [AW-1:0] addr_c;

  // Box edges in 11 bits: a sprite running past column/row 1023 clips instead of wrapping.
  assign x_lo   = {1'b0, org_x};
  assign x_hi   = x_lo + 11'(EW);
  assign y_lo   = {1'b0, cur_y};
  assign y_hi   = y_lo + 11'(EH);
  assign hit_c  = ({1'b0, beam_x} >= x_lo) && ({1'b0, beam_x} < x_hi) &&
                  ({1'b0, beam_y} >= y_lo) && ({1'b0, beam_y} < y_hi);
  assign col_c  = CW'((beam_x - org_x) >> SCALE_LOG2);
  assign addr_c = AW'((beam_y - cur_y) >> SCALE_LOG2);

  logic          hit1, hit2, en1, en2;
  logic [CW-1:0] col1, col2;
  logic          col_ok;
  logic [CW-1:0] bit_idx;

  // ROM words are MSB-first, so column 0 maps to bit SPR_W-1.
  always_comb begin
    col_ok  = {1'b0, col2} < (CW + 1)'(SPR_W);
    bit_idx = col_ok ? (CW'(SPR_W - 1) - col2) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1     <= 1'b0;
      en1      <= 1'b0;
      col1     <= '0;
      rom_addr <= '0;
      hit2     <= 1'b0;
      en2      <= 1'b0;
      col2     <= '0;
      visible  <= 1'b0;
    end else begin
      hit1 <= hit_c;
      en1  <= (state != IDLE) && phase;
      col1 <= col_c;
      if (hit_c) begin
        rom_addr <= addr_c;
      end
      hit2    <= hit1;
      en2     <= en1;
      col2    <= col1;
      visible <= hit2 && en2 && col_ok && rom_data[bit_idx];
    end
  end

endmodule

// File: tb/tb_sprite_banner_anim.sv
// Randomised and directed bench for sprite_banner_anim, two instances (scale x1 and x2)
// checked against a frame-level animation model and a behavioural glyph ROM.
module tb_sprite_banner_anim;

  localparam int SPR_W   = 90;
  localparam int SPR_H   = 16;
  localparam int START_Y = 0;
  localparam int STEP    = 4;
  localparam int BP      = 2;
  localparam int BT      = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [9:0]       beam_x, beam_y, org_x, tgt_y;
  logic             frame_tick, enable;
  logic [3:0]       rom_addr, rom_addr_s;
  logic [SPR_W-1:0] rom_data, rom_data_s;
  logic             visible, visible_s, busy, busy_s;

  logic [SPR_W-1:0] rom [SPR_H];
  bit               exp_q[$];
  bit               exp_sq[$];
  bit               m_on;
  int               m_ticks;
  bit               en_lvl;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data   <= rom[rom_addr];
    rom_data_s <= rom[rom_addr_s];
  end

  sprite_banner_anim #(.SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(0), .START_Y(START_Y),
                       .STEP(STEP), .BLINK_PERIOD(BP), .BLINK_TOGGLES(BT)) dut (
    .clk(clk), .rst_n(rst_n), .beam_x(beam_x), .beam_y(beam_y), .frame_tick(frame_tick),
    .enable(enable), .org_x(org_x), .tgt_y(tgt_y), .rom_addr(rom_addr), .rom_data(rom_data),
    .visible(visible), .busy(busy));

  sprite_banner_anim #(.SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(1), .START_Y(START_Y),
                       .STEP(STEP), .BLINK_PERIOD(BP), .BLINK_TOGGLES(BT)) dut_s (
    .clk(clk), .rst_n(rst_n), .beam_x(beam_x), .beam_y(beam_y), .frame_tick(frame_tick),
    .enable(enable), .org_x(org_x), .tgt_y(tgt_y), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .visible(visible_s), .busy(busy_s));

  // Animation model: everything derives from the tick count since the banner was enabled.
  function automatic int n_slide();
    if (START_Y >= int'(tgt_y)) return 1;
    return (int'(tgt_y) - START_Y + STEP - 1) / STEP;
  endfunction

  function automatic int model_y();
    if (m_ticks < n_slide()) return START_Y + m_ticks * STEP;
    return int'(tgt_y);
  endfunction

  function automatic bit model_phase();
    int j;
    if (m_ticks < n_slide()) return 1'b1;
    j = m_ticks - n_slide();
    if (j >= BP * BT) return 1'b1;
    return ((j / BP) % 2) == 0;
  endfunction

  function automatic bit model_busy();
    return m_on && (m_ticks < n_slide() + BP * BT);
  endfunction

  function automatic bit model_pix(int scale, int x, int y);
    int ew, eh, cy, ox, row, col;
    ew = SPR_W << scale;
    eh = SPR_H << scale;
    cy = model_y();
    ox = int'(org_x);
    if (!m_on || !model_phase()) return 1'b0;
    if (x < ox || x >= ox + ew || y < cy || y >= cy + eh) return 1'b0;
    row = (y - cy) >> scale;
    col = (x - ox) >> scale;
    return rom[row][SPR_W-1-col];
  endfunction

  function automatic int rand_x();
    int lo, hi;
    lo = (int'(org_x) > 8) ? int'(org_x) - 8 : 0;
    hi = (int'(org_x) + (SPR_W << 1) + 8 > 1023) ? 1023 : int'(org_x) + (SPR_W << 1) + 8;
    return int'($urandom_range(32'(hi), 32'(lo)));
  endfunction

  function automatic int rand_y();
    int lo, hi;
    lo = (model_y() > 4) ? model_y() - 4 : 0;
    hi = (model_y() + (SPR_H << 1) + 4 > 1023) ? 1023 : model_y() + (SPR_H << 1) + 4;
    return int'($urandom_range(32'(hi), 32'(lo)));
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive at the falling edge, predict, then check after the rising edge.
  task automatic drive_cycle(input int x, input int y, input bit tick);
    beam_x     = 10'(x);
    beam_y     = 10'(y);
    frame_tick = tick;
    enable     = en_lvl;
    exp_q.push_back(model_pix(0, x, y));
    exp_sq.push_back(model_pix(1, x, y));
    if (!en_lvl) begin
      m_on    = 1'b0;
      m_ticks = 0;
    end else if (!m_on) begin
      m_on    = 1'b1;
      m_ticks = 0;
    end else if (tick && m_ticks < 1000) begin
      m_ticks++;
    end
    @(negedge clk);
    frame_tick = 1'b0;
    check_output("busy", busy, model_busy());
    check_output("busy_s", busy_s, model_busy());
    if (exp_q.size() == 3) check_output("visible", visible, exp_q.pop_front());
    if (exp_sq.size() == 3) check_output("visible_s", visible_s, exp_sq.pop_front());
  endtask

  task automatic run_frame(input int n);
    repeat (n) drive_cycle(rand_x(), rand_y(), 1'b0);
    drive_cycle(rand_x(), rand_y(), 1'b1);
  endtask

  task automatic idle_cycle();
    drive_cycle(0, 1023, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; en_lvl = 1'b0;
    beam_x = '0; beam_y = '0; org_x = 10'd200; tgt_y = 10'd10;
    m_on = 1'b0; m_ticks = 0;
    for (int r = 0; r < SPR_H; r++)
      for (int b = 0; b < SPR_W; b++) rom[r][b] = 1'($urandom_range(1, 0));
    rom[0] = '1;
    rom[1][SPR_W-1] = 1'b1;
    rom[2][66] = 1'b1;

    #1;
    check_output("reset_visible", visible, 0);
    check_output("reset_rom_addr", rom_addr, 0);
    check_output("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) drive_cycle(rand_x(), rand_y(), 1'b0);

    $display("[TB] slide to row 10");
    en_lvl = 1'b1;
    idle_cycle();
    repeat (3) run_frame(20);
    drive_cycle(200, 10, 1'b0);
    idle_cycle(); idle_cycle();
    check_output("slide_hit", visible, 1);

    $display("[TB] blink phases");
    run_frame(20);
    run_frame(20);
    drive_cycle(200, 10, 1'b0);
    idle_cycle(); idle_cycle();
    check_output("blink_off", visible, 0);
    run_frame(20);
    run_frame(20);
    check_output("steady_busy", busy, 0);
    drive_cycle(200, 10, 1'b0);
    idle_cycle(); idle_cycle();
    check_output("steady_on", visible, 1);
    run_frame(10);

    $display("[TB] abort with simultaneous frame tick");
    en_lvl = 1'b0;
    idle_cycle();
    org_x = 10'd100; tgt_y = 10'd50;
    en_lvl = 1'b1;
    idle_cycle();
    run_frame(10);
    en_lvl = 1'b0;
    drive_cycle(rand_x(), rand_y(), 1'b1);
    check_output("abort_idle", busy, 0);
    en_lvl = 1'b1;
    idle_cycle();
    drive_cycle(100, 0, 1'b0);
    idle_cycle(); idle_cycle();
    check_output("restart_y", visible, 1);

    $display("[TB] scaled sprite at row 50");
    repeat (13) run_frame(8);
    drive_cycle(101, 53, 1'b0);
    check_output("scale_addr", rom_addr_s, 1);
    idle_cycle(); idle_cycle();
    check_output("scale_bit", visible_s, 1);
    drive_cycle(279, 50, 1'b0);
    idle_cycle(); idle_cycle();
    check_output("right_inside", visible_s, 1);
    drive_cycle(280, 50, 1'b0);
    idle_cycle(); idle_cycle();
    check_output("right_edge", visible_s, 0);

    $display("[TB] clipping at column 1023");
    en_lvl = 1'b0;
    idle_cycle();
    org_x = 10'd1000; tgt_y = 10'd20;
    en_lvl = 1'b1;
    idle_cycle();
    repeat (5) run_frame(8);
    drive_cycle(1023, 22, 1'b0);
    idle_cycle(); idle_cycle();
    check_output("clip_hit", visible, 1);
    for (int x = 0; x <= 10; x++) begin
      drive_cycle(x, 20, 1'b0);
      if (x >= 2) check_output("clip_nowrap", visible, 0);
    end

    $display("[TB] asynchronous reset mid-line");
    drive_cycle(1000, 20, 1'b0);
    drive_cycle(1001, 20, 1'b0);
    drive_cycle(1005, 23, 1'b0);
    check_output("pre_reset_vis", visible, 1);
    check_output("pre_reset_addr", rom_addr, 3);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_visible", visible, 0);
    check_output("async_rom_addr", rom_addr, 0);
    check_output("async_busy", busy, 0);
    exp_q.delete();
    exp_sq.delete();
    m_on = 1'b0;
    m_ticks = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("release_busy", busy, 0);
    idle_cycle();
    repeat (3) run_frame(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
